// File: rtl/paddle_ctrl.sv
// Pong match controller: serve/play/point/game-over sequencing, scoring and paddle step commands.
// Latency: up/down and paddle_rst are registered, appearing the cycle after the qualifying tick/event.
// Backpressure: none; frame_tick and score_event are single-cycle pulses consumed as they arrive.
module paddle_ctrl #(
    parameter logic [7:0] HEIGTH       = 8'd40,
    parameter int         MOVE_DIV     = 2,
    parameter int         AI_DEADBAND  = 4,
    parameter int         SERVE_FRAMES = 60,
    parameter int         POINT_FRAMES = 90,
    parameter logic [3:0] WIN_SCORE    = 4'd9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [1:0] btn_up,
    input  logic [1:0] btn_down,
    input  logic [1:0] ai_enable,
    input  logic [7:0] ball_x,
    input  logic [7:0] paddle_x0,
    input  logic [7:0] paddle_x1,
    input  logic [1:0] score_event,
    output logic [1:0] up,
    output logic [1:0] down,
    output logic       paddle_rst,
    output logic [2:0] state,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic       serve_side
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_e;

    // Frame counter must hold the longer of the two frame delays.
    localparam int FC_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int FCW    = $clog2(FC_MAX + 1);
    localparam int SCW    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    localparam logic [FCW-1:0] SERVE_LAST = FCW'(SERVE_FRAMES - 1);
    localparam logic [FCW-1:0] POINT_LAST = FCW'(POINT_FRAMES - 1);
    localparam logic [SCW-1:0] STEP_LAST  = SCW'(MOVE_DIV - 1);

    // AI arithmetic is done in 9 bits so paddle centre plus deadband never wraps.
    localparam logic [8:0] HALF_H = {1'b0, HEIGTH} >> 1;
    localparam logic [8:0] DB     = 9'(AI_DEADBAND);

    state_e         state_q;
    logic [FCW-1:0] frame_cnt_q;
    logic [SCW-1:0] step_cnt_q;
    logic [3:0]     score0_q;
    logic [3:0]     score1_q;
    logic           serve_side_q;
    logic           paddle_rst_q;
    logic [1:0]     up_q;
    logic [1:0]     down_q;

    logic [8:0] ball9;
    logic [8:0] center0;
    logic [8:0] center1;
    logic [1:0] ai_up;
    logic [1:0] ai_dn;
    logic [1:0] hum_up;
    logic [1:0] hum_dn;
    logic       step_tick;
    logic [1:0] up_d;
    logic [1:0] down_d;

    assign ball9   = {1'b0, ball_x};
    assign center0 = {1'b0, paddle_x0} + HALF_H;
    assign center1 = {1'b0, paddle_x1} + HALF_H;

    // Ball above the deadband window -> move up, below it -> move down.
    assign ai_up[0] = ball9 > (center0 + DB);
    assign ai_up[1] = ball9 > (center1 + DB);
    assign ai_dn[0] = (ball9 + DB) < center0;
    assign ai_dn[1] = (ball9 + DB) < center1;

    // Conflicting or absent buttons give no command.
    assign hum_up = btn_up & ~btn_down;
    assign hum_dn = btn_down & ~btn_up;

    assign step_tick = (state_q == ST_PLAY) && frame_tick && (step_cnt_q == STEP_LAST);

    // Select AI or human command per paddle, issued only on a step tick.
    always_comb begin
        up_d   = '0;
        down_d = '0;
        if (step_tick) begin
            up_d   = (ai_enable & ai_up) | (~ai_enable & hum_up);
            down_d = (ai_enable & ai_dn) | (~ai_enable & hum_dn);
        end
    end

    // Match FSM with its counters, scores and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= '0;
            step_cnt_q   <= '0;
            score0_q     <= '0;
            score1_q     <= '0;
            serve_side_q <= 1'b0;
            paddle_rst_q <= 1'b0;
            up_q         <= '0;
            down_q       <= '0;
        end else begin
            // A step tick in the same cycle as a score still delivers its command.
            up_q         <= up_d;
            down_q       <= down_d;
            paddle_rst_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_GAMEOVER: begin
                    if (start) begin
                        state_q      <= ST_SERVE;
                        frame_cnt_q  <= '0;
                        score0_q     <= '0;
                        score1_q     <= '0;
                        serve_side_q <= 1'b0;
                        paddle_rst_q <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == SERVE_LAST) begin
                            state_q     <= ST_PLAY;
                            frame_cnt_q <= '0;
                            step_cnt_q  <= '0;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (frame_tick) begin
                        step_cnt_q <= (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + 1'b1;
                    end
                    if (score_event == 2'b01) begin
                        if (score0_q < WIN_SCORE) begin
                            score0_q <= score0_q + 4'd1;
                        end
                        serve_side_q <= 1'b1;
                        state_q      <= ST_POINT;
                        frame_cnt_q  <= '0;
                    end else if (score_event == 2'b10) begin
                        if (score1_q < WIN_SCORE) begin
                            score1_q <= score1_q + 4'd1;
                        end
                        serve_side_q <= 1'b0;
                        state_q      <= ST_POINT;
                        frame_cnt_q  <= '0;
                    end
                end
                ST_POINT: begin
                    if ((score0_q == WIN_SCORE) || (score1_q == WIN_SCORE)) begin
                        state_q     <= ST_GAMEOVER;
                        frame_cnt_q <= '0;
                    end else if (frame_tick) begin
                        if (frame_cnt_q == POINT_LAST) begin
                            state_q      <= ST_SERVE;
                            frame_cnt_q  <= '0;
                            paddle_rst_q <= 1'b1;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    frame_cnt_q <= '0;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign score0     = score0_q;
    assign score1     = score1_q;
    assign serve_side = serve_side_q;
    assign paddle_rst = paddle_rst_q;
    assign up         = up_q;
    assign down       = down_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with default parameters.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
// Every check goes through chk(); the summary reports vectors and miscompares.
module tb_paddle_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic [1:0] btn_up;
    logic [1:0] btn_down;
    logic [1:0] ai_enable;
    logic [7:0] ball_x;
    logic [7:0] paddle_x0;
    logic [7:0] paddle_x1;
    logic [1:0] score_event;
    logic [1:0] up;
    logic [1:0] down;
    logic       paddle_rst;
    logic [2:0] state;
    logic [3:0] score0;
    logic [3:0] score1;
    logic       serve_side;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                           S_POINT = 3'd3, S_OVER = 3'd4;

    paddle_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .start       (start),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .ai_enable   (ai_enable),
        .ball_x      (ball_x),
        .paddle_x0   (paddle_x0),
        .paddle_x1   (paddle_x1),
        .score_event (score_event),
        .up          (up),
        .down        (down),
        .paddle_rst  (paddle_rst),
        .state       (state),
        .score0      (score0),
        .score1      (score1),
        .serve_side  (serve_side)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // n frames, each a tick cycle followed by a quiet cycle
    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
        end
    endtask

    // Two frames starting from step counter 0: only the second tick steps.
    task automatic step_pair(input string tag, input logic [1:0] exp_up, input logic [1:0] exp_dn);
        frame_tick = 1'b1;
        cyc();
        chk({tag, "_t1_up"}, up, 2'b00);
        chk({tag, "_t1_dn"}, down, 2'b00);
        frame_tick = 1'b0;
        cyc();
        frame_tick = 1'b1;
        cyc();
        chk({tag, "_t2_up"}, up, exp_up);
        chk({tag, "_t2_dn"}, down, exp_dn);
        frame_tick = 1'b0;
        cyc();
        chk({tag, "_idle_up"}, up, 2'b00);
    endtask

    task automatic pulse_score(input logic [1:0] ev);
        score_event = ev;
        cyc();
        score_event = 2'b00;
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
        btn_up = 2'b00; btn_down = 2'b00; ai_enable = 2'b00;
        ball_x = 8'd0; paddle_x0 = 8'd100; paddle_x1 = 8'd100; score_event = 2'b00;
        cyc();
        cyc();
        chk("rst_state", state, S_IDLE);
        chk("rst_updn", {up, down}, 4'b0000);
        chk("rst_prst", paddle_rst, 1'b0);
        chk("rst_scores", {score0, score1}, 8'h00);
        chk("rst_serve", serve_side, 1'b0);

        // Start: SERVE with a single paddle_rst pulse
        reset = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_state", state, S_SERVE);
        chk("start_prst", paddle_rst, 1'b1);
        cyc();
        chk("start_prst_off", paddle_rst, 1'b0);
        pulse_score(2'b01);
        chk("serve_ignore_ev", score0, 4'd0);
        frames(59);
        chk("serve_59", state, S_SERVE);
        frames(1);
        chk("serve_60", state, S_PLAY);

        // Human paddle 0 up, MOVE_DIV=2: pulses after ticks 2, 4, 6 only
        btn_up = 2'b01;
        for (int t = 1; t <= 6; t++) begin
            frame_tick = 1'b1;
            cyc();
            chk($sformatf("hum_up_t%0d", t), up, (t % 2 == 0) ? 2'b01 : 2'b00);
            chk($sformatf("hum_dn_t%0d", t), down, 2'b00);
            frame_tick = 1'b0;
            cyc();
            chk($sformatf("hum_idle_t%0d", t), up, 2'b00);
        end
        btn_down = 2'b01;
        step_pair("hum_both", 2'b00, 2'b00);
        btn_up = 2'b00;
        step_pair("hum_down", 2'b00, 2'b01);
        btn_down = 2'b00;

        // AI paddle 1: centre = 100 + 20 = 120, deadband 4
        ai_enable = 2'b10;
        ball_x = 8'd130; step_pair("ai_130", 2'b10, 2'b00);
        ball_x = 8'd118; step_pair("ai_118", 2'b00, 2'b00);
        ball_x = 8'd110; step_pair("ai_110", 2'b00, 2'b10);
        ball_x = 8'd124; step_pair("ai_124", 2'b00, 2'b00);
        ball_x = 8'd125; step_pair("ai_125", 2'b10, 2'b00);
        ball_x = 8'd116; step_pair("ai_116", 2'b00, 2'b00);
        ball_x = 8'd115; step_pair("ai_115", 2'b00, 2'b10);
        ai_enable = 2'b00;

        // Simultaneous score events are ignored
        pulse_score(2'b11);
        chk("ev11_state", state, S_PLAY);
        chk("ev11_scores", {score0, score1}, 8'h00);

        // Step tick coinciding with a score still yields its command
        btn_up = 2'b01;
        frames(1);
        frame_tick = 1'b1;
        score_event = 2'b01;
        cyc();
        frame_tick = 1'b0;
        score_event = 2'b00;
        chk("coinc_up", up, 2'b01);
        chk("coinc_state", state, S_POINT);
        chk("coinc_score0", score0, 4'd1);
        chk("coinc_serve", serve_side, 1'b1);
        cyc();
        chk("point_up_off", up, 2'b00);
        btn_up = 2'b00;

        // POINT holds 90 frames, then SERVE with paddle_rst
        frames(89);
        chk("point_89", state, S_POINT);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("point_90_state", state, S_SERVE);
        chk("point_90_prst", paddle_rst, 1'b1);
        cyc();
        chk("point_prst_off", paddle_rst, 1'b0);
        frames(60);
        chk("replay_state", state, S_PLAY);
        chk("replay_serve", serve_side, 1'b1);

        // Drive score0 up to 8
        for (int s = 2; s <= 8; s++) begin
            pulse_score(2'b01);
            chk($sformatf("score0_%0d", s), score0, 32'(s));
            frames(90);
            frames(60);
        end
        chk("pre_win_state", state, S_PLAY);

        // Winning point: POINT then GAMEOVER the next cycle
        pulse_score(2'b01);
        chk("win_score0", score0, 4'd9);
        chk("win_point", state, S_POINT);
        cyc();
        chk("win_over", state, S_OVER);
        pulse_score(2'b10);
        cyc();
        chk("over_held", {score0, score1}, 8'h90);
        chk("over_state", state, S_OVER);

        // Restart from GAMEOVER
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_state", state, S_SERVE);
        chk("restart_scores", {score0, score1}, 8'h00);
        chk("restart_prst", paddle_rst, 1'b1);
        chk("restart_serve", serve_side, 1'b0);
        frames(60);
        pulse_score(2'b10);
        chk("p1_score", score1, 4'd1);
        chk("p1_serve", serve_side, 1'b0);
        chk("p1_state", state, S_POINT);

        // Reset mid-POINT with frame counter at 45, start and score asserted too
        frames(45);
        reset = 1'b1;
        start = 1'b1;
        score_event = 2'b01;
        cyc();
        chk("mid_rst_state", state, S_IDLE);
        chk("mid_rst_updn", {up, down}, 4'b0000);
        chk("mid_rst_prst", paddle_rst, 1'b0);
        chk("mid_rst_scores", {score0, score1}, 8'h00);
        chk("mid_rst_serve", serve_side, 1'b0);
        cyc();
        chk("mid_rst_hold", state, S_IDLE);
        chk("mid_rst_prst2", paddle_rst, 1'b0);
        reset = 1'b0;
        start = 1'b0;
        score_event = 2'b00;
        cyc();
        chk("post_rst_idle", state, S_IDLE);

        // Counters restart from 0 after reset
        start = 1'b1;
        cyc();
        start = 1'b0;
        frames(59);
        chk("post_rst_serve59", state, S_SERVE);
        frames(1);
        chk("post_rst_serve60", state, S_PLAY);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameters SHALL be: HEIGTH, default 8'd40, paddle height in pixels; MOVE_DIV, default 2, frame ticks per paddle step; AI_DEADBAND, default 4, AI no-move half-window in pixels; SERVE_FRAMES, default 60, serve delay in frames; POINT_FRAMES, default 90, post-point hold in frames; WIN_SCORE, default 4'd9, winning score.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 frame_tick  input  1  one-cycle pulse per video frame.
REQ-005 start  input  1  level; starts a match from IDLE or GAMEOVER.
REQ-006 btn_up, btn_down  input  2 each  human controls; bit i = paddle i.
REQ-007 ai_enable  input  2  bit i set: paddle i is AI-driven.
REQ-008 ball_x  input  8  current ball vertical position.
REQ-009 paddle_x0, paddle_x1  input  8 each  current paddle vertical positions.
REQ-010 score_event  input  2  one-cycle pulse; bit i set: player i scored.
REQ-011 up, down  output  2 each  registered one-cycle step commands to paddle i.
REQ-012 paddle_rst  output  1  registered one-cycle pulse re-centering both paddles.
REQ-013 state  output  3  encoded FSM state.
REQ-014 score0, score1  output  4 each  player scores.
REQ-015 serve_side  output  1  player receiving the serve.

Function
REQ-016 FSM states SHALL be IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4.
REQ-017 IDLE: start=1 -> SERVE; scores cleared to 0, serve_side=0, paddle_rst pulsed in the cycle after the transition.
REQ-018 SERVE: frame counter SHALL count frame_ticks; on the SERVE_FRAMES-th tick -> PLAY, counter cleared.
REQ-019 PLAY: score_event=2'b01 -> score0+1, serve_side=1, -> POINT; 2'b10 -> score1+1, serve_side=0, -> POINT; 2'b11 or 2'b00 -> no change.
REQ-020 POINT: if either score equals WIN_SCORE -> GAMEOVER immediately on next cycle; else on the POINT_FRAMES-th frame_tick -> SERVE with paddle_rst pulsed once.
REQ-021 GAMEOVER: scores held; start=1 -> SERVE with scores cleared, serve_side=0, paddle_rst pulsed.
REQ-022 score_event outside PLAY SHALL be ignored; scores saturate at WIN_SCORE.
REQ-023 Step counter: in PLAY, counts frame_ticks modulo MOVE_DIV; a step occurs on the tick where the counter equals MOVE_DIV-1; counter cleared on every entry to PLAY.
REQ-024 up/down SHALL be asserted only in the cycle after a step tick, for exactly one cycle, and never both for the same paddle.
REQ-025 Human paddle (ai_enable[i]=0): btn_up only -> up[i]; btn_down only -> down[i]; both or neither -> no command.
REQ-026 AI paddle: center = paddle_x + HEIGTH/2 computed 9-bit; ball_x > center + AI_DEADBAND -> up[i]; ball_x + AI_DEADBAND < center -> down[i]; else none; all comparisons 9-bit, no wrap.
REQ-027 Outside PLAY, up and down SHALL be 0; a step tick coinciding with a score_event SHALL still produce its command.
REQ-028 Frame counter SHALL be wide enough for max(SERVE_FRAMES, POINT_FRAMES) and cleared on every state change.

Reset
REQ-029 reset=1 at a rising edge SHALL force state=IDLE, up=down=0, paddle_rst=0, score0=score1=0, serve_side=0, all counters 0, regardless of the current state; reset dominates start and score_event.

Verification
REQ-030 reset, start=1 one cycle -> state=SERVE, paddle_rst=1 for exactly one cycle; after 60 frame_ticks state=PLAY.
REQ-031 PLAY, human, btn_up[0]=1, MOVE_DIV=2, 6 frame_ticks -> exactly 3 up[0] pulses, each one cycle after the even-numbered tick; btn_up=btn_down=1 -> none.
REQ-032 PLAY, ai_enable[1]=1, paddle_x1=100, ball_x=130 -> up[1] per step; ball_x=118 -> none; ball_x=110 -> down[1].
REQ-033 PLAY, score_event=2'b01 -> score0=1, serve_side=1, state=POINT; 2'b11 -> scores unchanged, state PLAY.
REQ-034 score0=8, score_event=2'b01 -> score0=9, POINT then GAMEOVER next cycle; start=1 -> scores 0, SERVE, paddle_rst pulse.
REQ-035 reset asserted mid-POINT with frame counter at 45 -> next cycle IDLE, all outputs 0, no paddle_rst pulse.
